sd_data_fifo: RTL

- Synchronous data FIFO between the ADMA engine and the SD data-line serializer/deserializer.
- In SD write direction the ADMA pushes 32-bit words from host RAM and the serializer pops them. In read direction the roles swap; the same instance is reused, and the direction is chosen outside this block.
- Exports fifo_full and fifo_empty consumed by the ADMA state machine, plus occupancy, watermarks and sticky overflow/underflow flags for the error status register.

---
 rtl/sd_fifo_defines.sv | 10 +
 rtl/sd_fifo_mem.sv | 33 +++
 rtl/sd_data_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/sd_fifo_defines.sv
// rtl/sd_fifo_defines.sv - shared widths, depth and default watermarks for the SD data FIFO
package sd_fifo_defines;

  localparam int SD_DATA_WIDTH       = 32;
  localparam int SD_ADDR_WIDTH       = 4;
  localparam int SD_FIFO_DEPTH       = 1 << SD_ADDR_WIDTH;
  localparam int SD_ALMOST_FULL_LVL  = 12;
  localparam int SD_ALMOST_EMPTY_LVL = 4;

endpackage

// File: rtl/sd_fifo_mem.sv
// rtl/sd_fifo_mem.sv - register array with a synchronous write port and a registered read port
module sd_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; a same-address write in this cycle is not seen (old data wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sd_data_fifo.sv
// rtl/sd_data_fifo.sv - data FIFO between the ADMA engine and the SD data-line serializer
module sd_data_fifo
  import sd_fifo_defines::*;
#(
  parameter int DATA_WIDTH       = SD_DATA_WIDTH,
  parameter int ADDR_WIDTH       = SD_ADDR_WIDTH,
  parameter int ALMOST_FULL_LVL  = SD_ALMOST_FULL_LVL,
  parameter int ALMOST_EMPTY_LVL = SD_ALMOST_EMPTY_LVL
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL);

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                dv_q, dv_d;
  logic                full_w, empty_w;
  logic                push_acc, pop_acc;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                   (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  assign pop_acc  = read_en && !empty_w && !flush;
  assign push_acc = write_en && (!full_w || pop_acc) && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dv_d    = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (push_acc) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop_acc) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + (ADDR_WIDTH+1)'(push_acc) - (ADDR_WIDTH+1)'(pop_acc);
      if (write_en && !push_acc) begin
        ovf_d = 1'b1;
      end
      if (read_en && !pop_acc) begin
        unf_d = 1'b1;
      end
      dv_d = pop_acc;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dv_q    <= dv_d;
    end
  end

  sd_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (CLK),
    .rst_n   (RESET),
    .wr_en   (push_acc),
    .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data (data_out)
  );

  assign data_valid   = dv_q;
  assign fifo_full    = full_w;
  assign fifo_empty   = empty_w;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign word_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
